// File: rtl/codeword_link_pkg.sv
// Shared line-framing types and constants for the codeword serializer/deserializer pair.
// Build option: PARITY_BIT_EN adds an even-parity bit after the data bits.
package codeword_link_pkg;

    localparam int CW_W = 16;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

`ifdef PARITY_BIT_EN
    localparam int FRAME_BITS = 19;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} ser_state_t;
`else
    localparam int FRAME_BITS = 18;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} ser_state_t;
`endif

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, bit_tick marks the last cycle of a bit.
// Combinational tick from the count register; clear holds the count at zero.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] count;

    assign bit_tick = (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || bit_tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/codeword_serializer.sv
// UART-style transmitter for 16-bit codewords: start, 16 data bits MSB first, [parity], stop.
// Build option: PARITY_BIT_EN inserts an even-parity bit; cw_ready is high only while idle.
module codeword_serializer #(
    parameter int CW_W         = 16,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CW_W-1:0] cw_in,
    input  logic            cw_valid,
    output logic            cw_ready,
    output logic            tx_out,
    output logic            tx_busy,
    output logic            frame_done
);

    import codeword_link_pkg::*;

    ser_state_t      state;
    logic [CW_W-1:0] shreg;
    logic [3:0]      bit_idx;
    logic            bit_tick;
    logic            timer_clr;
`ifdef PARITY_BIT_EN
    logic            par_bit;
`endif

    assign cw_ready  = (state == IDLE);
    assign tx_busy   = (state != IDLE);
    assign timer_clr = (state == IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clr),
        .bit_tick(bit_tick)
    );

    // tx_out is loaded with the level of the state being entered, so the line
    // changes in the same cycle the state register does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            tx_out     <= LINE_IDLE;
            frame_done <= 1'b0;
`ifdef PARITY_BIT_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cw_valid) begin
                        shreg   <= cw_in;
                        bit_idx <= '0;
                        state   <= START;
                        tx_out  <= LINE_START;
`ifdef PARITY_BIT_EN
                        par_bit <= ^cw_in;
`endif
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state  <= DATA;
                        tx_out <= shreg[CW_W-1];
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shreg <= {shreg[CW_W-2:0], 1'b0};
                        if (bit_idx == 4'(CW_W - 1)) begin
`ifdef PARITY_BIT_EN
                            state  <= PARITY;
                            tx_out <= par_bit;
`else
                            state  <= STOP;
                            tx_out <= LINE_IDLE;
`endif
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            tx_out  <= shreg[CW_W-2];
                        end
                    end
                end
`ifdef PARITY_BIT_EN
                PARITY: begin
                    if (bit_tick) begin
                        state  <= STOP;
                        tx_out <= LINE_IDLE;
                    end
                end
`endif
                STOP: begin
                    if (bit_tick) begin
                        state      <= IDLE;
                        tx_out     <= LINE_IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= LINE_IDLE;
                end
            endcase
        end
    end

endmodule
